// File: rtl/cdb_buffer_pkg.sv
// Shared widths and types for the common data bus result buffer.
// Width macros default here unless the surrounding system defines them first.
`ifndef WAYS
`define WAYS 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF
`define PRF 64
`endif

package cdb_buffer_pkg;

    localparam int WAYS       = `WAYS;
    localparam int XLEN       = `XLEN;
    localparam int PRF_IDX_W  = $clog2(`PRF);
    localparam int LANE_CNT_W = $clog2(WAYS + 1);

    typedef logic [XLEN-1:0]       data_t;
    typedef logic [PRF_IDX_W-1:0]  prf_idx_t;
    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

    // Broadcast packet as seen by the reservation stations and the ROB.
    typedef struct packed {
        logic     valid;
        data_t    data;
        prf_idx_t prf_idx;
    } CDB_PACKET;

    typedef struct packed {
        data_t    data;
        prf_idx_t prf_idx;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_compact.sv
// Maps each valid FU lane to its slot offset from the tail, ascending lane order,
// and reports how many lanes are valid in total.
module cdb_compact
    import cdb_buffer_pkg::*;
(
    input  logic      [WAYS-1:0] lane_valid,
    output lane_cnt_t [WAYS-1:0] lane_offset,
    output lane_cnt_t            lane_count
);

    always_comb begin
        lane_cnt_t running;
        // NOTE: blocking assignments here build a running prefix sum within one evaluation.
        running = '0;
        for (int i = 0; i < WAYS; i++) begin
            lane_offset[i] = running;
            running        = running + lane_cnt_t'(lane_valid[i]);
        end
        lane_count = running;
    end

endmodule

// File: rtl/cdb_buffer.sv
// Circular result buffer between the functional units and the CDB; broadcasts
// up to WAYS oldest entries per cycle straight from registered state.
module cdb_buffer
    import cdb_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 squash,
    input  logic [`WAYS-1:0]                     fu_valid,
    input  logic [`WAYS-1:0][`XLEN-1:0]          fu_data,
    input  logic [`WAYS-1:0][$clog2(`PRF)-1:0]   fu_prf_idx,
    output logic                                 fu_ready,
    output logic [`WAYS-1:0]                     CDB_valid,
    output logic [`WAYS-1:0][`XLEN-1:0]          CDB_Data,
    output logic [`WAYS-1:0][$clog2(`PRF)-1:0]   CDB_PRF_idx,
    output logic [$clog2(DEPTH):0]               num_used
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    cdb_entry_t             mem [DEPTH];
    ptr_t                   head;
    ptr_t                   tail;
    lane_cnt_t [WAYS-1:0]   enq_offset;
    lane_cnt_t              enq_count;
    lane_cnt_t              deq_count;
    CDB_PACKET [WAYS-1:0]   cdb_pkt;

    cdb_compact u_compact (
        .lane_valid  (fu_valid),
        .lane_offset (enq_offset),
        .lane_count  (enq_count)
    );

    // Admission looks only at registered occupancy so FUs never see a path from the retire side.
    assign fu_ready  = (cnt_t'(DEPTH) - num_used) >= cnt_t'(WAYS);
    assign deq_count = (num_used >= cnt_t'(WAYS)) ? lane_cnt_t'(WAYS) : lane_cnt_t'(num_used);

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            // NOTE: every lane gets a default before the conditional fill, so no latch is inferred.
            cdb_pkt[i] = '0;
            if (lane_cnt_t'(i) < deq_count) begin
                cdb_pkt[i].valid   = 1'b1;
                cdb_pkt[i].data    = mem[head + ptr_t'(i)].data;
                cdb_pkt[i].prf_idx = mem[head + ptr_t'(i)].prf_idx;
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            CDB_valid[i]   = cdb_pkt[i].valid;
            CDB_Data[i]    = cdb_pkt[i].data;
            CDB_PRF_idx[i] = cdb_pkt[i].prf_idx;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head     <= '0;
            tail     <= '0;
            num_used <= '0;
        end else begin
            head     <= head + ptr_t'(deq_count);
            tail     <= tail + (fu_ready ? ptr_t'(enq_count) : ptr_t'(0));
            num_used <= num_used - cnt_t'(deq_count)
                      + (fu_ready ? cnt_t'(enq_count) : cnt_t'(0));
        end
    end

    // NOTE: entry storage is not reset; occupancy masks stale contents at the outputs.
    always_ff @(posedge clock) begin
        if (fu_ready) begin
            for (int i = 0; i < WAYS; i++) begin
                if (fu_valid[i]) begin
                    mem[tail + ptr_t'(enq_offset[i])] <= '{data: fu_data[i], prf_idx: fu_prf_idx[i]};
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_buffer.sv
// Directed bench for cdb_buffer with WAYS=3, DEPTH=8: latency, throughput, backpressure,
// wrap-around ordering, squash and reset.
module tb_cdb_buffer;
    import cdb_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic                                clock = 1'b0;
    logic                                reset;
    logic                                squash;
    logic [WAYS-1:0]                     fu_valid;
    logic [WAYS-1:0][XLEN-1:0]           fu_data;
    logic [WAYS-1:0][PRF_IDX_W-1:0]      fu_prf_idx;
    logic                                fu_ready;
    logic [WAYS-1:0]                     CDB_valid;
    logic [WAYS-1:0][XLEN-1:0]           CDB_Data;
    logic [WAYS-1:0][PRF_IDX_W-1:0]      CDB_PRF_idx;
    logic [$clog2(DEPTH):0]              num_used;

    int tests_run    = 0;
    int tests_failed = 0;

    cdb_buffer #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .fu_valid    (fu_valid),
        .fu_data     (fu_data),
        .fu_prf_idx  (fu_prf_idx),
        .fu_ready    (fu_ready),
        .CDB_valid   (CDB_valid),
        .CDB_Data    (CDB_Data),
        .CDB_PRF_idx (CDB_PRF_idx),
        .num_used    (num_used)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [XLEN-1:0] data_of(input int tag);
        return 32'hC0DE_0000 | XLEN'(tag);
    endfunction

    function automatic logic [WAYS-1:0] therm(input int n);
        return WAYS'((1 << n) - 1);
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [WAYS-1:0] v, input int t0, input int t1, input int t2);
        fu_valid      = v;
        fu_prf_idx[0] = PRF_IDX_W'(t0);
        fu_prf_idx[1] = PRF_IDX_W'(t1);
        fu_prf_idx[2] = PRF_IDX_W'(t2);
        fu_data[0]    = data_of(t0);
        fu_data[1]    = data_of(t1);
        fu_data[2]    = data_of(t2);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_num_used"}, 64'(num_used), 64'd0);
        check({tag, "_valid"},    64'(CDB_valid), 64'd0);
        check({tag, "_ready"},    64'(fu_ready), 64'd1);
        for (int j = 0; j < WAYS; j++) begin
            check($sformatf("%s_idx%0d", tag, j),  64'(CDB_PRF_idx[j]), 64'd0);
            check($sformatf("%s_data%0d", tag, j), 64'(CDB_Data[j]), 64'd0);
        end
    endtask

    logic [WAYS-1:0] pat [10];
    int              exp_q [$];

    initial begin
        int next_tag;
        int popped;
        int n;
        int lane_tag [WAYS];

        reset  = 1'b1;
        squash = 1'b0;
        drive(3'b000, 0, 0, 0);
        @(negedge clock);
        step();
        reset = 1'b0;
        check_idle("reset");

        // Two valid lanes with a gap: compacted onto lanes 0 and 1 one cycle later.
        drive(3'b101, 5, 7, 9);
        step();
        drive(3'b000, 0, 0, 0);
        check("lat_valid", 64'(CDB_valid), 64'b011);
        check("lat_idx0",  64'(CDB_PRF_idx[0]), 64'd5);
        check("lat_idx1",  64'(CDB_PRF_idx[1]), 64'd9);
        check("lat_idx2",  64'(CDB_PRF_idx[2]), 64'd0);
        check("lat_data0", 64'(CDB_Data[0]), 64'(data_of(5)));
        check("lat_data1", 64'(CDB_Data[1]), 64'(data_of(9)));
        check("lat_data2", 64'(CDB_Data[2]), 64'd0);
        check("lat_used",  64'(num_used), 64'd2);
        step();
        check("lat_drain_used",  64'(num_used), 64'd0);
        check("lat_drain_valid", 64'(CDB_valid), 64'd0);

        // Full-width issue for four cycles: occupancy holds at 3, tags in issue order.
        for (int k = 0; k < 4; k++) begin
            drive(3'b111, 10 + 3 * k, 11 + 3 * k, 12 + 3 * k);
            step();
            check($sformatf("full%0d_used", k),  64'(num_used), 64'd3);
            check($sformatf("full%0d_ready", k), 64'(fu_ready), 64'd1);
            check($sformatf("full%0d_valid", k), 64'(CDB_valid), 64'b111);
            for (int j = 0; j < WAYS; j++)
                check($sformatf("full%0d_idx%0d", k, j), 64'(CDB_PRF_idx[j]), 64'(10 + 3 * k + j));
        end
        drive(3'b000, 0, 0, 0);
        step();
        check("full_drain_used", 64'(num_used), 64'd0);

        // Backpressure: with 6 entries held, admission closes and offered lanes are dropped.
        force dut.num_used = 4'd6;
        #1;
        check("bp_ready_low", 64'(fu_ready), 64'd0);
        check("bp_valid",     64'(CDB_valid), 64'b111);
        drive(3'b111, 40, 41, 42);
        release dut.num_used;
        step();
        drive(3'b000, 0, 0, 0);
        check("bp_used_after",  64'(num_used), 64'd3);
        check("bp_ready_again", 64'(fu_ready), 64'd1);

        reset = 1'b1;
        step();
        reset = 1'b0;

        // Twenty entries through the ring with mixed lane patterns; scoreboard tracks order.
        pat = '{3'b111, 3'b010, 3'b000, 3'b110, 3'b101, 3'b111, 3'b001, 3'b011, 3'b111, 3'b111};
        next_tag = 30;
        popped   = 0;
        for (int c = 0; c < 16; c++) begin
            n = (exp_q.size() < WAYS) ? exp_q.size() : WAYS;
            check($sformatf("wrap%0d_used", c),  64'(num_used), 64'(exp_q.size()));
            check($sformatf("wrap%0d_valid", c), 64'(CDB_valid), 64'(therm(n)));
            for (int j = 0; j < n; j++)
                check($sformatf("wrap%0d_idx%0d", c, j), 64'(CDB_PRF_idx[j]), 64'(exp_q[j]));
            for (int j = 0; j < n; j++)
                void'(exp_q.pop_front());
            popped += n;
            for (int j = 0; j < WAYS; j++) begin
                lane_tag[j] = 0;
                if (c < 10 && pat[c][j]) begin
                    lane_tag[j] = next_tag;
                    exp_q.push_back(next_tag);
                    next_tag++;
                end
            end
            drive((c < 10) ? pat[c] : 3'b000, lane_tag[0], lane_tag[1], lane_tag[2]);
            step();
        end
        check("wrap_total_issued", 64'(next_tag - 30), 64'd20);
        check("wrap_total_seen",   64'(popped), 64'd20);

        // Squash with 5 held and a same-cycle enqueue: flush wins, current broadcast stays.
        force dut.num_used = 4'd5;
        squash = 1'b1;
        drive(3'b011, 50, 51, 0);
        #1;
        check("sq_cur_valid", 64'(CDB_valid), 64'b111);
        release dut.num_used;
        step();
        squash = 1'b0;
        drive(3'b000, 0, 0, 0);
        check("sq_used",  64'(num_used), 64'd0);
        check("sq_valid", 64'(CDB_valid), 64'd0);
        step();
        check("sq_no_late_valid", 64'(CDB_valid), 64'd0);

        // Reset mid-operation with 4 held and a full enqueue offered.
        force dut.num_used = 4'd4;
        #1;
        release dut.num_used;
        reset = 1'b1;
        drive(3'b111, 60, 61, 62);
        step();
        reset = 1'b0;
        drive(3'b000, 0, 0, 0);
        check_idle("midreset");
        step();
        check("midreset_no_late_valid", 64'(CDB_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cdb_buffer.md
CDB_BUFFER -- requirements
Module: cdb_buffer

Interface
REQ-001 Parameter DEPTH, default 8, buffer entries; power of two, SHALL be >= 2*`WAYS.
REQ-002 Widths `WAYS, `XLEN, `PRF SHALL come from sys_defs.svh macros and SHALL NOT be module parameters.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 squash  input  1  synchronous flush of all buffered results.
REQ-006 fu_valid  input  [`WAYS-1:0]  per-lane FU completion; any bit pattern is legal.
REQ-007 fu_data  input  [`WAYS-1:0][`XLEN-1:0]  per-lane result value.
REQ-008 fu_prf_idx  input  [`WAYS-1:0][$clog2(`PRF)-1:0]  per-lane destination PRF index.
REQ-009 fu_ready  output  1  high when all `WAYS lanes can be accepted this cycle.
REQ-010 CDB_valid  output  [`WAYS-1:0]  broadcast valid, LSB-packed thermometer (0, 1, 11, 111...).
REQ-011 CDB_Data  output  [`WAYS-1:0][`XLEN-1:0]  broadcast values.
REQ-012 CDB_PRF_idx  output  [`WAYS-1:0][$clog2(`PRF)-1:0]  broadcast tags.
REQ-013 num_used  output  [$clog2(DEPTH):0]  current occupancy (debug and test).

Function
REQ-014 Buffer SHALL be a circular FIFO with head pointer, tail pointer and occupancy count; pointers wrap modulo DEPTH.
REQ-015 fu_ready SHALL equal (DEPTH - num_used) >= `WAYS, using registered num_used only, independent of same-cycle dequeue.
REQ-016 On posedge with fu_ready high, each valid lane SHALL be written at consecutive tail slots in ascending lane order, invalid lanes skipped; tail advances by popcount(fu_valid).
REQ-017 When fu_ready is low, fu_valid SHALL be ignored; FUs hold their results until fu_ready is high.
REQ-018 Outputs SHALL be driven from registered head entries only: n = min(num_used, `WAYS) oldest entries on lanes 0..n-1 in FIFO order.
REQ-019 CDB_valid SHALL have exactly the n low bits set; lanes >= n SHALL drive CDB_Data and CDB_PRF_idx as zero.
REQ-020 Every presented entry SHALL be retired at the same posedge; head advances by n; no downstream stall exists.
REQ-021 Enqueue-to-broadcast latency SHALL be exactly 1 cycle when older entries do not block; no combinational path from fu_* to CDB_*.
REQ-022 Simultaneous enqueue and dequeue SHALL give num_used_next = num_used - n + popcount(fu_valid & {`WAYS{fu_ready}}).
REQ-023 Order SHALL be preserved across wrap-around; an entry SHALL never be broadcast twice or dropped.
REQ-024 squash SHALL zero num_used, head and tail at the next posedge and override any same-cycle enqueue; current-cycle CDB outputs are unaffected.
REQ-025 Arithmetic on count and pointers SHALL use $clog2(DEPTH)+1 and $clog2(DEPTH) bits respectively; no overflow is reachable given REQ-015.

Reset
REQ-026 On reset: num_used=0, head=0, tail=0, CDB_valid=0, CDB_Data=0, CDB_PRF_idx=0, fu_ready=1 in the following cycle.
REQ-027 reset SHALL dominate squash and enqueue; reset asserted mid-operation discards all buffered entries.
REQ-028 Entry storage need not be cleared on reset; outputs SHALL be masked by occupancy.

Structure
REQ-029 Typedef CDB_PACKET {valid, data, prf_idx} SHALL be added to sys_defs.svh for shared use by RS and ROB.
REQ-030 One sub-module, cdb_compact (combinational lane compaction to slot offsets), is natural; FIFO state SHALL stay in cdb_buffer.

Verification (`WAYS=3, DEPTH=8)
REQ-031 Reset, then fu_valid=3'b101 with tags 5, 9 -> next cycle CDB_valid=3'b011, CDB_PRF_idx lane0=5, lane1=9, lane2=0; num_used=0 after.
REQ-032 Four cycles of fu_valid=3'b111 with no outputs consumed beyond 3/cycle -> num_used stays at or below 3; order of tags exactly as issued.
REQ-033 Preload num_used=6 -> fu_ready=0; fu_valid=3'b111 ignored; num_used drops to 3 next cycle; fu_ready=1 again.
REQ-034 Drive 20 entries with pointer wrap past index 7 -> broadcast tag sequence matches enqueue sequence, no duplicates or losses.
REQ-035 squash with num_used=5 and fu_valid=3'b011 same cycle -> next cycle num_used=0, CDB_valid=0.
REQ-036 reset asserted while num_used=4 -> next cycle all outputs zero, fu_ready=1.
